// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: USB receive sequencer (SYNC detect, NRZI decode, destuff, byte assembly, EOP and error reporting) on i_clk_4x/i_rst_n, line i_dp/i_dn qualified by i_sample_en, outputs o_rx_active/o_data/o_valid/o_eop/o_err
module usb_rx_ctrl #(
  parameter int MIN_SYNC_ZEROS = 5,
  parameter int IDLE_J_BITS = 7
) (
  input  logic       i_clk_4x,
  input  logic       i_rst_n,
  input  logic       i_sample_en,
  input  logic       i_dp,
  input  logic       i_dn,
  output logic       o_rx_active,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_eop,
  output logic       o_err
);
  localparam logic [2:0] s_idle = 3'd0;
  localparam logic [2:0] s_sync = 3'd1;
  localparam logic [2:0] s_data = 3'd2;
  localparam logic [2:0] s_eop1 = 3'd3;
  localparam logic [2:0] s_eop2 = 3'd4;
  localparam logic [2:0] s_abort = 3'd5;
  localparam logic [3:0] min_z = 4'(MIN_SYNC_ZEROS);
  localparam logic [3:0] j_last = 4'(IDLE_J_BITS - 1);
  logic [2:0] state;
  logic       prev_j;
  logic [3:0] zcnt;
  logic [2:0] bcnt;
  logic [2:0] ones;
  logic [7:0] shift;
  logic [3:0] jcnt;
  logic       j, k, se0, se1, jk, dbit, err;
  assign j = i_dp & ~i_dn;
  assign k = ~i_dp & i_dn;
  assign se0 = ~i_dp & ~i_dn;
  assign se1 = i_dp & i_dn;
  assign jk = j | k;
  assign dbit = j == prev_j;
  assign err = i_sample_en & (state == s_sync & se1
             | state == s_data & (se1 | se0 & bcnt != 3'd0 | jk & ones == 3'd6 & dbit)
             | state == s_eop1 & ~se0
             | state == s_eop2 & ~j);
  always_ff @(posedge i_clk_4x or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= s_idle;
      prev_j <= 1'b1;
      zcnt <= '0;
      bcnt <= '0;
      ones <= '0;
      shift <= '0;
      jcnt <= '0;
      o_rx_active <= 1'b0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_eop <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_eop <= 1'b0;
      o_err <= 1'b0;
      if (i_sample_en) begin
        if (jk) prev_j <= j;
        if (err) begin
          state <= s_abort;
          jcnt <= '0;
          o_err <= 1'b1;
          o_rx_active <= 1'b0;
        end else begin
          case (state)
            s_idle: if (k) begin
              state <= s_sync;
              zcnt <= 4'd1;
            end
            s_sync: if (se0) state <= s_idle;
            else if (!dbit) zcnt <= zcnt == 4'd15 ? zcnt : zcnt + 4'd1;
            else if (zcnt >= min_z) begin
              state <= s_data;
              bcnt <= '0;
              ones <= 3'd1;
              o_rx_active <= 1'b1;
            end else state <= s_idle;
            s_data: if (se0) state <= s_eop1;
            else if (ones == 3'd6) ones <= '0;
            else begin
              shift <= {dbit, shift[7:1]};
              bcnt <= bcnt + 3'd1;
              ones <= dbit ? ones + 3'd1 : 3'd0;
              if (bcnt == 3'd7) begin
                o_data <= {dbit, shift[7:1]};
                o_valid <= 1'b1;
              end
            end
            s_eop1: state <= s_eop2;
            s_eop2: begin
              state <= s_idle;
              o_eop <= 1'b1;
              o_rx_active <= 1'b0;
            end
            s_abort: begin
              jcnt <= j ? jcnt + 4'd1 : 4'd0;
              if (j && jcnt == j_last) state <= s_idle;
            end
            default: state <= s_idle;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: directed self-checking bench for usb_rx_ctrl
module tb_usb_rx_ctrl;
  logic       i_clk_4x = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_sample_en = 1'b0;
  logic       i_dp = 1'b1;
  logic       i_dn = 1'b0;
  logic       o_rx_active;
  logic [7:0] o_data;
  logic       o_valid, o_eop, o_err;
  int         cmp = 0;
  int         mis = 0;
  int         n_valid = 0;
  int         n_eop = 0;
  int         n_err = 0;
  logic [7:0] last_data = '0;
  logic       p_valid, p_eop, p_err;
  logic       line_j = 1'b1;
  int         v0, e0, r0;
  usb_rx_ctrl dut (
    .i_clk_4x(i_clk_4x),
    .i_rst_n(i_rst_n),
    .i_sample_en(i_sample_en),
    .i_dp(i_dp),
    .i_dn(i_dn),
    .o_rx_active(o_rx_active),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_eop(o_eop),
    .o_err(o_err)
  );
  always #5 i_clk_4x = ~i_clk_4x;
  always @(negedge i_clk_4x) begin
    if (o_valid) begin
      n_valid <= n_valid + 1;
      last_data <= o_data;
    end
    if (o_eop) n_eop <= n_eop + 1;
    if (o_err) n_err <= n_err + 1;
  end
  task automatic strobe(input logic dp, input logic dn);
    @(negedge i_clk_4x);
    i_dp = dp;
    i_dn = dn;
    i_sample_en = 1'b1;
    @(negedge i_clk_4x);
    i_sample_en = 1'b0;
    p_valid = o_valid;
    p_eop = o_eop;
    p_err = o_err;
    repeat (2) @(negedge i_clk_4x);
  endtask
  task automatic send_j();
    line_j = 1'b1;
    strobe(1'b1, 1'b0);
  endtask
  task automatic send_k();
    line_j = 1'b0;
    strobe(1'b0, 1'b1);
  endtask
  task automatic send_se0();
    strobe(1'b0, 1'b0);
  endtask
  task automatic send_bit(input logic b);
    if (!b) line_j = ~line_j;
    strobe(line_j, ~line_j);
  endtask
  task automatic send_sync();
    repeat (3) begin
      send_k();
      send_j();
    end
    send_k();
    send_k();
  endtask
  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask
  task automatic snap();
    v0 = n_valid;
    e0 = n_eop;
    r0 = n_err;
  endtask
  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk_4x);
    cmp++;
    if ({o_rx_active, o_valid, o_eop, o_err, o_data} !== 12'h000) begin
      mis++;
      $display("FAIL reset_outputs got %h want 000", {o_rx_active, o_valid, o_eop, o_err, o_data});
    end
    i_rst_n = 1'b1;
    snap();
    repeat (20) send_j();
    cmp++;
    if ({n_valid - v0, n_eop - e0, n_err - r0} !== {32'd0, 32'd0, 32'd0}) begin
      mis++;
      $display("FAIL idle_j_pulses got v%0d e%0d r%0d want 0 0 0", n_valid - v0, n_eop - e0, n_err - r0);
    end
    cmp++;
    if (o_rx_active !== 1'b0) begin
      mis++;
      $display("FAIL idle_rx_active got %b want 0", o_rx_active);
    end
  endtask
  task automatic test_packet_a5();
    snap();
    send_sync();
    cmp++;
    if (o_rx_active !== 1'b1) begin
      mis++;
      $display("FAIL a5_rx_active got %b want 1", o_rx_active);
    end
    send_byte(8'hA5);
    cmp++;
    if (p_valid !== 1'b1 || o_data !== 8'hA5) begin
      mis++;
      $display("FAIL a5_valid got v%b d%h want v1 dA5", p_valid, o_data);
    end
    send_se0();
    send_se0();
    send_j();
    cmp++;
    if (p_eop !== 1'b1 || o_rx_active !== 1'b0) begin
      mis++;
      $display("FAIL a5_eop got eop%b act%b want 1 0", p_eop, o_rx_active);
    end
    cmp++;
    if ({n_valid - v0, n_eop - e0, n_err - r0} !== {32'd1, 32'd1, 32'd0}) begin
      mis++;
      $display("FAIL a5_counts got v%0d e%0d r%0d want 1 1 0", n_valid - v0, n_eop - e0, n_err - r0);
    end
  endtask
  task automatic test_stuff_ff();
    snap();
    send_sync();
    repeat (5) send_bit(1'b1);
    send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    cmp++;
    if (p_valid !== 1'b1 || last_data !== 8'hFF) begin
      mis++;
      $display("FAIL ff_valid got v%b d%h want v1 dFF", p_valid, last_data);
    end
    send_se0();
    send_se0();
    send_j();
    cmp++;
    if ({n_valid - v0, n_eop - e0, n_err - r0} !== {32'd1, 32'd1, 32'd0}) begin
      mis++;
      $display("FAIL ff_counts got v%0d e%0d r%0d want 1 1 0", n_valid - v0, n_eop - e0, n_err - r0);
    end
  endtask
  task automatic test_stuff_error();
    snap();
    send_sync();
    repeat (5) send_bit(1'b1);
    cmp++;
    if (p_err !== 1'b0) begin
      mis++;
      $display("FAIL stuff_early_err got %b want 0", p_err);
    end
    send_bit(1'b1);
    cmp++;
    if (p_err !== 1'b1 || o_rx_active !== 1'b0) begin
      mis++;
      $display("FAIL stuff_err got err%b act%b want 1 0", p_err, o_rx_active);
    end
    send_bit(1'b1);
    repeat (6) send_j();
    send_sync();
    send_byte(8'h3C);
    send_se0();
    send_se0();
    send_j();
    cmp++;
    if ({n_valid - v0, n_eop - e0, n_err - r0} !== {32'd0, 32'd0, 32'd1}) begin
      mis++;
      $display("FAIL abort_hold got v%0d e%0d r%0d want 0 0 1", n_valid - v0, n_eop - e0, n_err - r0);
    end
    repeat (7) send_j();
    send_sync();
    send_byte(8'h5A);
    send_se0();
    send_se0();
    send_j();
    cmp++;
    if ({n_valid - v0, n_eop - e0, last_data} !== {32'd1, 32'd1, 8'h5A}) begin
      mis++;
      $display("FAIL abort_recover got v%0d e%0d d%h want 1 1 5A", n_valid - v0, n_eop - e0, last_data);
    end
  endtask
  task automatic test_short_frame();
    snap();
    send_sync();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_se0();
    cmp++;
    if (p_err !== 1'b1 || o_rx_active !== 1'b0) begin
      mis++;
      $display("FAIL frame_err got err%b act%b want 1 0", p_err, o_rx_active);
    end
    repeat (7) send_j();
    cmp++;
    if ({n_eop - e0, n_err - r0} !== {32'd0, 32'd1}) begin
      mis++;
      $display("FAIL frame_counts got e%0d r%0d want 0 1", n_eop - e0, n_err - r0);
    end
  endtask
  task automatic test_short_sync();
    snap();
    send_k();
    send_j();
    send_k();
    send_k();
    cmp++;
    if (o_rx_active !== 1'b0 || {n_valid - v0, n_eop - e0, n_err - r0} !== {32'd0, 32'd0, 32'd0}) begin
      mis++;
      $display("FAIL short_sync got act%b v%0d e%0d r%0d want 0 0 0 0", o_rx_active, n_valid - v0, n_eop - e0, n_err - r0);
    end
    send_sync();
    cmp++;
    if (o_rx_active !== 1'b1) begin
      mis++;
      $display("FAIL resync_active got %b want 1", o_rx_active);
    end
    send_byte(8'hC3);
    send_se0();
    send_se0();
    send_j();
    cmp++;
    if ({n_valid - v0, n_eop - e0, n_err - r0, last_data} !== {32'd1, 32'd1, 32'd0, 8'hC3}) begin
      mis++;
      $display("FAIL resync_pkt got v%0d e%0d r%0d d%h want 1 1 0 C3", n_valid - v0, n_eop - e0, n_err - r0, last_data);
    end
  endtask
  task automatic test_freeze();
    snap();
    send_sync();
    @(negedge i_clk_4x);
    i_dp = 1'b1;
    i_dn = 1'b1;
    repeat (12) @(negedge i_clk_4x);
    cmp++;
    if (o_rx_active !== 1'b1 || n_err != r0) begin
      mis++;
      $display("FAIL freeze got act%b r%0d want 1 0", o_rx_active, n_err - r0);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge i_clk_4x);
    i_rst_n = 1'b0;
    #1;
    cmp++;
    if (o_rx_active !== 1'b0) begin
      mis++;
      $display("FAIL midreset_active got %b want 0", o_rx_active);
    end
    i_dp = 1'b1;
    i_dn = 1'b0;
    line_j = 1'b1;
    repeat (3) @(negedge i_clk_4x);
    i_rst_n = 1'b1;
    repeat (3) send_j();
    cmp++;
    if ({n_eop - e0, n_err - r0} !== {32'd0, 32'd0}) begin
      mis++;
      $display("FAIL midreset_pulses got e%0d r%0d want 0 0", n_eop - e0, n_err - r0);
    end
    send_sync();
    send_byte(8'h81);
    send_se0();
    send_se0();
    send_j();
    cmp++;
    if ({n_valid - v0, n_eop - e0, last_data} !== {32'd1, 32'd1, 8'h81}) begin
      mis++;
      $display("FAIL post_reset_pkt got v%0d e%0d d%h want 1 1 81", n_valid - v0, n_eop - e0, last_data);
    end
  endtask
  initial begin
    test_reset();
    test_packet_a5();
    test_stuff_ff();
    test_stuff_error();
    test_short_frame();
    test_short_sync();
    test_freeze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

USB receive sequencer sitting directly after the sample-position adjuster. It consumes one line sample per bit period, qualified by the adjuster's sample-enable strobe. It detects SYNC, NRZI-decodes, removes stuffed bits, assembles bytes LSB-first and detects EOP, reporting bytes, packet end and line errors to the packet layer. It owns the receive state machine; the adjuster only supplies bit timing.

## Interface
- MIN_SYNC_ZEROS, 5: minimum decoded 0s before the terminating SYNC 1 for a valid SYNC (tolerates lost leading bits).
- IDLE_J_BITS, 7: consecutive J samples that end the ABORT state.

- i_clk_4x  in  1  4x bit-rate clock, shared with the sample-position adjuster.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_sample_en  in  1  one-cycle strobe, one per bit period; all line processing happens only in strobed cycles.
- i_dp, i_dn  in  1 each  synchronized differential line. J = dp1/dn0, K = dp0/dn1, SE0 = 00, SE1 = 11.
- o_rx_active  out  1  high while in DATA, EOP1 or EOP2.
- o_data  out  8  last assembled byte; holds until the next byte.
- o_valid  out  1  one-cycle pulse per byte.
- o_eop  out  1  one-cycle pulse on a good EOP.
- o_err  out  1  one-cycle pulse on a stuff, SE1 or framing error.

## Operation
- NRZI: decoded bit = 1 if the line state equals the previous strobed J/K state, else 0.
  - Previous state updates only on J or K samples.
  - Reset value of previous state: J.
- States: IDLE, SYNC, DATA, EOP1, EOP2, ABORT.
- IDLE:
  - K sample -> SYNC, with zero count = 1.
  - J, SE0 and SE1 samples are ignored.
- SYNC:
  - Decoded 0 -> zero count += 1, saturating at 15.
  - Decoded 1 with zero count >= MIN_SYNC_ZEROS -> DATA, with bit count = 0 and ones count = 1 (the SYNC terminating 1 counts toward stuffing).
  - Decoded 1 with fewer zeros -> IDLE, no outputs.
  - SE0 -> IDLE, no outputs.
  - SE1 -> o_err, then ABORT.
- DATA, J/K sample:
  - If ones count == 6: a decoded 0 is a stuff bit. Drop it and clear ones count. A decoded 1 -> o_err, then ABORT.
  - Otherwise shift the bit into shift[7] (right shift, LSB first) and increment bit count (3 bits).
    - Ones count: +1 on a 1, cleared on a 0.
    - When bit count wraps 7 -> 0: o_data <= assembled byte, o_valid pulse.
- DATA, SE0 sample:
  - Bit count == 0 -> EOP1.
  - Otherwise -> o_err, then ABORT.
  - A pending stuff bit (ones count == 6) at SE0 is not an error.
- DATA, SE1 sample: o_err, then ABORT.
- EOP1: SE0 -> EOP2; any other sample -> o_err, then ABORT.
- EOP2: J -> o_eop pulse, then IDLE; any other sample -> o_err, then ABORT.
- ABORT:
  - Counts consecutive J samples; any non-J sample clears the count.
  - Count reaching IDLE_J_BITS -> IDLE.
  - Produces no outputs while in this state.
- Previous-line tracking continues in every state, so NRZI stays aligned after abort.

## Timing
- Reset (async assert, sync release on i_clk_4x):
  - State IDLE, previous line J, all counters 0.
  - o_data = 0x00; o_valid, o_eop, o_err, o_rx_active = 0.
- All outputs are registered. The state and outputs update on the i_clk_4x edge that samples i_sample_en = 1.
  - Pulses are visible in the following cycle and last exactly one i_clk_4x cycle.
- Latency:
  - o_valid: 1 clock after the strobe carrying the 8th data bit.
  - o_eop: 1 clock after the strobe carrying the J after the second SE0.
- o_rx_active rises 1 clock after the strobe carrying the SYNC terminating 1. It falls with o_eop or o_err.
- Non-strobed cycles: no state change, and pulses deassert.
- Only one of o_valid, o_eop or o_err can pulse for a given strobe.
- Reset mid-packet aborts immediately, with no o_err and no o_eop.
- With i_sample_en held low, the block is frozen.

## Test plan
- Reset with the line at J: all outputs 0; 20 strobes of J -> no pulses; o_rx_active = 0.
- Idle J, then KJKJKJKK, then the NRZI encoding of 0xA5, then SE0, SE0, J:
  - exactly one o_valid with o_data = 0xA5;
  - o_eop 1 clock after the J strobe;
  - o_err never asserted.
- SYNC, then 0xFF with a stuff 0 inserted after the 5th data 1, then EOP:
  - o_data = 0xFF;
  - o_valid once, o_eop once;
  - no o_err.
- SYNC, then seven consecutive decoded 1s with no stuff bit:
  - o_err on the 6th data 1 following the SYNC 1;
  - no o_valid;
  - returns to IDLE only after 7 consecutive J strobes.
- SYNC, then 3 data bits, then SE0 -> o_err, no o_eop, o_rx_active drops.
- Short SYNC (idle J, then KJKK) -> back to IDLE silently: no pulses and o_rx_active stays 0. A full SYNC immediately afterwards is accepted.
